// File: rtl/gdiv_sequencer_if.sv
// Request/response handshake bundle between the FP divide front end and gdiv_sequencer.
// The front end takes the master modport and the sequencer takes the slave modport.
interface gdiv_sequencer_if #(
   parameter int WIDTH = 23
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_m1;
   logic [WIDTH-1:0] in_m2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_m3;
   logic             out_dec_exp;
   logic             out_inexact;

   modport master (
      output in_valid, in_m1, in_m2, out_ready,
      input  in_ready, out_valid, out_m3, out_dec_exp, out_inexact
   );

   modport slave (
      input  in_valid, in_m1, in_m2, out_ready,
      output in_ready, out_valid, out_m3, out_dec_exp, out_inexact
   );
endinterface

// File: rtl/gdiv_sequencer.sv
// Operation-level controller for the Goldschmidt mantissa divider: accepts one operand
// pair, steps the divider through seed/iterate/remainder phases and holds the result.
module gdiv_sequencer #(
   parameter int WIDTH   = 23,
   parameter int ITERS   = 3,
   parameter int MUL_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   gdiv_sequencer_if.slave  bus,
   output logic             busy,
   output logic [WIDTH-1:0] dp_m1,
   output logic [WIDTH-1:0] dp_m2,
   output logic             dp_mode,
   output logic             dp_stage,
   output logic             dp_rem,
   input  logic [WIDTH-1:0] dp_m3,
   input  logic             dp_dec_exp,
   input  logic             dp_rem_sign,
   input  logic             dp_rem_zero
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ITER = 3'd2,
      REM  = 3'd3,
      CAPT = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [1:0] CYC_LAST  = 2'(MUL_LAT - 1);
   localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);

   state_t           state;
   logic [1:0]       cyc_cnt;
   logic [3:0]       iter_cnt;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_m3_r;
   logic             out_dec_exp_r;
   logic             out_inexact_r;

   // Remainder sign is kept on the port for a future rounding step.
   logic unused_rem_sign;
   assign unused_rem_sign = dp_rem_sign;

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_m3      = out_m3_r;
   assign bus.out_dec_exp = out_dec_exp_r;
   assign bus.out_inexact = out_inexact_r;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cyc_cnt       <= '0;
         iter_cnt      <= '0;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         busy          <= 1'b0;
         dp_mode       <= 1'b0;
         dp_stage      <= 1'b0;
         dp_rem        <= 1'b0;
         dp_m1         <= '0;
         dp_m2         <= '0;
         out_m3_r      <= '0;
         out_dec_exp_r <= 1'b0;
         out_inexact_r <= 1'b0;
      end else if (flush) begin
         // Abort wins over accept and over the response handshake; result data is kept.
         state       <= IDLE;
         cyc_cnt     <= '0;
         iter_cnt    <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy        <= 1'b0;
         dp_mode     <= 1'b0;
         dp_stage    <= 1'b0;
         dp_rem      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  dp_m1      <= bus.in_m1;
                  dp_m2      <= bus.in_m2;
                  state      <= LOAD;
                  in_ready_r <= 1'b0;
                  busy       <= 1'b1;
                  dp_mode    <= 1'b0;
                  dp_stage   <= 1'b0;
               end
            end
            LOAD: begin
               state    <= ITER;
               dp_mode  <= 1'b1;
               dp_stage <= 1'b0;
               cyc_cnt  <= '0;
               iter_cnt <= '0;
            end
            ITER: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  if (!dp_stage) begin
                     dp_stage <= 1'b1;
                  end else begin
                     dp_stage <= 1'b0;
                     if (iter_cnt == ITER_LAST) begin
                        iter_cnt <= '0;
                        state    <= REM;
                        dp_rem   <= 1'b1;
                     end else begin
                        iter_cnt <= iter_cnt + 4'd1;
                     end
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 2'd1;
               end
            end
            REM: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  state   <= CAPT;
                  dp_mode <= 1'b0;
                  dp_rem  <= 1'b0;
               end else begin
                  cyc_cnt <= cyc_cnt + 2'd1;
               end
            end
            CAPT: begin
               out_m3_r      <= dp_m3;
               out_dec_exp_r <= dp_dec_exp;
               out_inexact_r <= ~dp_rem_zero;
               out_valid_r   <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy        <= 1'b0;
               dp_mode     <= 1'b0;
               dp_stage    <= 1'b0;
               dp_rem      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gdiv_sequencer.sv
// Directed bench for gdiv_sequencer: default-parameter instance plus an ITERS=2/MUL_LAT=3
// instance, each fed by a behavioural divider that answers combinationally.
module tb_gdiv_sequencer;

   localparam int W = 23;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   gdiv_sequencer_if #(.WIDTH(W)) bus1 ();
   gdiv_sequencer_if #(.WIDTH(W)) bus2 ();

   logic         busy1, busy2;
   logic [W-1:0] dp_m1_1, dp_m2_1, dp_m3_1, dp_m1_2, dp_m2_2, dp_m3_2;
   logic         dp_mode1, dp_stage1, dp_rem1, dp_dec1, dp_rsign1, dp_rzero1;
   logic         dp_mode2, dp_stage2, dp_rem2, dp_dec2, dp_rsign2, dp_rzero2;

   gdiv_sequencer #(.WIDTH(W), .ITERS(3), .MUL_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus1), .busy(busy1),
      .dp_m1(dp_m1_1), .dp_m2(dp_m2_1), .dp_mode(dp_mode1), .dp_stage(dp_stage1),
      .dp_rem(dp_rem1), .dp_m3(dp_m3_1), .dp_dec_exp(dp_dec1),
      .dp_rem_sign(dp_rsign1), .dp_rem_zero(dp_rzero1)
   );

   gdiv_sequencer #(.WIDTH(W), .ITERS(2), .MUL_LAT(3)) dut2 (
      .clk(clk), .reset(reset), .flush(1'b0), .bus(bus2), .busy(busy2),
      .dp_m1(dp_m1_2), .dp_m2(dp_m2_2), .dp_mode(dp_mode2), .dp_stage(dp_stage2),
      .dp_rem(dp_rem2), .dp_m3(dp_m3_2), .dp_dec_exp(dp_dec2),
      .dp_rem_sign(dp_rsign2), .dp_rem_zero(dp_rzero2)
   );

   // Behavioural divider: {dec_exp, rem_zero, quotient fraction} of 1.a / 1.b.
   function automatic logic [W+1:0] div_model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] n, d, q, r;
      logic        dec;
      n = 64'(a) | (64'd1 << W);
      d = 64'(b) | (64'd1 << W);
      if (n >= d) begin
         n   = n << W;
         dec = 1'b0;
      end else begin
         n   = n << (W + 1);
         dec = 1'b1;
      end
      q = n / d;
      r = n % d;
      return {dec, (r == 64'd0), q[W-1:0]};
   endfunction

   always_comb begin
      {dp_dec1, dp_rzero1, dp_m3_1} = div_model(dp_m1_1, dp_m2_1);
      {dp_dec2, dp_rzero2, dp_m3_2} = div_model(dp_m1_2, dp_m2_2);
      dp_rsign1 = 1'b0;
      dp_rsign2 = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request to dut1 for one edge; returns cycles from accept to out_valid.
   task automatic run_op1(input logic [W-1:0] m1, input logic [W-1:0] m2, output int lat);
      bus1.in_valid = 1'b1;
      bus1.in_m1    = m1;
      bus1.in_m2    = m2;
      tick();
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [11:0] pat;
      int          rem_cyc;

      bus1.in_valid = 1'b0; bus1.in_m1 = '0; bus1.in_m2 = '0; bus1.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_m1 = '0; bus2.in_m2 = '0; bus2.out_ready = 1'b1;
      #12;
      check("rst_in_ready", 32'(bus1.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_dp_ctrl", {29'd0, dp_mode1, dp_stage1, dp_rem1}, 32'd0);
      check("rst_out_m3", 32'(bus1.out_m3), 32'd0);
      reset = 1'b1;
      tick();

      // 1) 1.0 / 1.0
      run_op1(23'h0, 23'h0, lat);
      check("t1_latency", 32'(lat), 32'd9);
      check("t1_m3", 32'(bus1.out_m3), 32'h0);
      check("t1_dec", 32'(bus1.out_dec_exp), 32'd0);
      check("t1_inexact", 32'(bus1.out_inexact), 32'd0);
      check("t1_dp_ctrl_done", {29'd0, dp_mode1, dp_stage1, dp_rem1}, 32'd0);
      tick();
      check("t1_in_ready_back", 32'(bus1.in_ready), 32'd1);
      check("t1_out_valid_drop", 32'(bus1.out_valid), 32'd0);

      // 2) 1.0 / 1.5
      run_op1(23'h0, 23'h400000, lat);
      check("t2_latency", 32'(lat), 32'd9);
      check("t2_m3", 32'(bus1.out_m3), 32'h2AAAAA);
      check("t2_dec", 32'(bus1.out_dec_exp), 32'd1);
      check("t2_inexact", 32'(bus1.out_inexact), 32'd1);
      tick();

      // 3) backpressure on 1.5 / 1.0
      bus1.out_ready = 1'b0;
      run_op1(23'h400000, 23'h0, lat);
      check("t3_latency", 32'(lat), 32'd9);
      bus1.in_valid = 1'b1;
      bus1.in_m1 = 23'h7FFFFF;
      for (int i = 0; i < 20; i++) begin
         check("t3_hold_valid", 32'(bus1.out_valid), 32'd1);
         check("t3_hold_m3", 32'(bus1.out_m3), 32'h400000);
         check("t3_hold_in_ready", 32'(bus1.in_ready), 32'd0);
         tick();
      end
      check("t3_dec", 32'(bus1.out_dec_exp), 32'd0);
      check("t3_inexact", 32'(bus1.out_inexact), 32'd0);
      bus1.in_valid = 1'b0;
      bus1.out_ready = 1'b1;
      tick();
      check("t3_release_valid", 32'(bus1.out_valid), 32'd0);
      check("t3_release_ready", 32'(bus1.in_ready), 32'd1);
      run_op1(23'h200000, 23'h0, lat);
      check("t3_next_latency", 32'(lat), 32'd9);
      check("t3_next_m3", 32'(bus1.out_m3), 32'h200000);
      tick();

      // 4) flush in the fourth ITER cycle, with a competing request
      bus1.in_valid = 1'b1; bus1.in_m1 = 23'h123456; bus1.in_m2 = 23'h0;
      tick();
      bus1.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t4_in_iter", {30'd0, dp_mode1, dp_rem1}, 32'd2);
      flush = 1'b1;
      bus1.in_valid = 1'b1; bus1.in_m1 = 23'h7FFFFF; bus1.in_m2 = 23'h7FFFFF;
      tick();
      flush = 1'b0;
      bus1.in_valid = 1'b0;
      check("t4_flush_busy", 32'(busy1), 32'd0);
      check("t4_flush_in_ready", 32'(bus1.in_ready), 32'd1);
      check("t4_flush_dp_ctrl", {29'd0, dp_mode1, dp_stage1, dp_rem1}, 32'd0);
      check("t4_flush_out_m3_kept", 32'(bus1.out_m3), 32'h200000);
      check("t4_flush_dp_m1_kept", 32'(dp_m1_1), 32'h123456);
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus1.out_valid) lat++;
         tick();
      end
      check("t4_no_out_valid", 32'(lat), 32'd0);
      run_op1(23'h0, 23'h400000, lat);
      check("t4_after_latency", 32'(lat), 32'd9);
      check("t4_after_m3", 32'(bus1.out_m3), 32'h2AAAAA);
      check("t4_after_dec", 32'(bus1.out_dec_exp), 32'd1);
      tick();

      // 5) ITERS=2, MUL_LAT=3 schedule on dut2
      bus2.in_valid = 1'b1; bus2.in_m1 = 23'h0; bus2.in_m2 = 23'h400000;
      tick();
      bus2.in_valid = 1'b0;
      check("t5_load_mode", 32'(dp_mode2), 32'd0);
      tick();
      pat = '0;
      for (int i = 0; i < 12; i++) begin
         pat[11-i] = dp_stage2;
         tick();
      end
      check("t5_stage_pattern", 32'(pat), 32'b000111000111);
      rem_cyc = 0;
      for (int i = 0; i < 3; i++) begin
         if (dp_rem2 && !dp_stage2 && dp_mode2) rem_cyc++;
         tick();
      end
      check("t5_rem_cycles", 32'(rem_cyc), 32'd3);
      check("t5_rem_off", 32'(dp_rem2), 32'd0);
      check("t5_valid_at_16", 32'(bus2.out_valid), 32'd0);
      tick();
      check("t5_valid_at_17", 32'(bus2.out_valid), 32'd1);
      check("t5_m3", 32'(bus2.out_m3), 32'h2AAAAA);
      tick();

      // 6) async reset while in REM
      bus1.in_valid = 1'b1; bus1.in_m1 = 23'h400000; bus1.in_m2 = 23'h0;
      tick();
      bus1.in_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("t6_in_rem", 32'(dp_rem1), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_busy", 32'(busy1), 32'd0);
      check("t6_rst_in_ready", 32'(bus1.in_ready), 32'd1);
      check("t6_rst_dp_ctrl", {29'd0, dp_mode1, dp_stage1, dp_rem1}, 32'd0);
      check("t6_rst_dp_m1", 32'(dp_m1_1), 32'd0);
      check("t6_rst_out_m3", 32'(bus1.out_m3), 32'd0);
      check("t6_rst_out_dec", 32'(bus1.out_dec_exp), 32'd0);
      #1 reset = 1'b1;
      tick();
      run_op1(23'h200000, 23'h0, lat);
      check("t6_after_latency", 32'(lat), 32'd9);
      check("t6_after_m3", 32'(bus1.out_m3), 32'h200000);
      check("t6_after_inexact", 32'(bus1.out_inexact), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
